// File: rtl/key_counter_display.sv
// Debounced up/down/clear key counter with hold-to-repeat and a multiplexed hex display.
// Keys are raw active-low inputs; the counter is 4*DIGITS bits wide and drives one nibble per digit.
module key_counter_display #(
    parameter int unsigned DIGITS            = 4,
    parameter int unsigned WRAP              = 1,
    parameter int unsigned REPEAT_EN         = 1,
    parameter int unsigned DEB_CYCLES        = 1_000_000,
    parameter int unsigned REP_DELAY_CYCLES  = 25_000_000,
    parameter int unsigned REP_PERIOD_CYCLES = 5_000_000,
    parameter int unsigned SCAN_CYCLES       = 50_000
) (
    input  logic                  FPGA_CLK,
    input  logic                  RESET_BUT,
    input  logic                  KEY_INC,
    input  logic                  KEY_DEC,
    input  logic                  KEY_CLR,
    output logic [4*DIGITS-1:0]   count,
    output logic                  step_pulse,
    output logic [DIGITS-1:0]     dig_n,
    output logic [6:0]            seg_n,
    output logic                  dot_n
);

    localparam int unsigned CW      = 4 * DIGITS;
    localparam int unsigned DW      = $clog2(DEB_CYCLES + 1);
    localparam int unsigned REP_MAX = (REP_DELAY_CYCLES > REP_PERIOD_CYCLES) ?
                                      REP_DELAY_CYCLES : REP_PERIOD_CYCLES;
    localparam int unsigned HW      = $clog2(REP_MAX + 1);
    localparam int unsigned SW      = $clog2(SCAN_CYCLES + 1);
    localparam int unsigned IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Key index 0 = INC, 1 = DEC, 2 = CLR; levels are active-low like the pins.
    logic [2:0]    raw;
    logic [2:0]    sync1_q, sync2_q;
    logic [2:0]    lvl_q;
    logic [2:0]    prev_q;
    logic [2:0]    press_q;
    logic [DW-1:0] deb_q [3];

    assign raw = {KEY_CLR, KEY_DEC, KEY_INC};

    always_ff @(posedge FPGA_CLK) begin
        if (!RESET_BUT) begin
            sync1_q <= '1;
            sync2_q <= '1;
            lvl_q   <= '1;
            prev_q  <= '0;
            press_q <= '0;
            for (int i = 0; i < 3; i++) deb_q[i] <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 3; i++) begin
                if (sync2_q[i] != lvl_q[i]) begin
                    if (deb_q[i] == DW'(DEB_CYCLES - 1)) begin
                        lvl_q[i] <= ~lvl_q[i];
                        deb_q[i] <= '0;
                    end else begin
                        deb_q[i] <= deb_q[i] + DW'(1);
                    end
                end else begin
                    deb_q[i] <= '0;
                end
            end
            prev_q  <= ~lvl_q;
            press_q <= ~lvl_q & ~prev_q;
        end
    end

    // Hold counters restart at every emitted event, so the target switches from delay to period.
    logic [HW-1:0] hold_q [2];
    logic [1:0]    phase_q;
    logic [1:0]    fire;

    always_comb begin
        fire = '0;
        for (int i = 0; i < 2; i++) begin
            fire[i] = (REPEAT_EN != 0) && !lvl_q[i] && !press_q[i] &&
                      (hold_q[i] == (phase_q[i] ? HW'(REP_PERIOD_CYCLES) : HW'(REP_DELAY_CYCLES)));
        end
    end

    always_ff @(posedge FPGA_CLK) begin
        if (!RESET_BUT) begin
            phase_q <= '0;
            for (int i = 0; i < 2; i++) hold_q[i] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (lvl_q[i]) begin
                    hold_q[i]  <= '0;
                    phase_q[i] <= 1'b0;
                end else if (press_q[i] || fire[i]) begin
                    hold_q[i]  <= HW'(1);
                    phase_q[i] <= phase_q[i] | fire[i];
                end else begin
                    hold_q[i]  <= hold_q[i] + HW'(1);
                end
            end
        end
    end

    logic          inc_ev, dec_ev, clr_ev;
    logic [CW-1:0] count_q, count_d;
    logic          step_q;

    assign inc_ev = press_q[0] | fire[0];
    assign dec_ev = press_q[1] | fire[1];
    assign clr_ev = press_q[2];

    always_comb begin
        count_d = count_q;
        if (clr_ev) begin
            count_d = '0;
        end else if (inc_ev && dec_ev) begin
            count_d = count_q;
        end else if (inc_ev) begin
            if ((WRAP != 0) || (count_q != '1)) count_d = count_q + CW'(1);
        end else if (dec_ev) begin
            if ((WRAP != 0) || (count_q != '0)) count_d = count_q - CW'(1);
        end
    end

    function automatic logic [6:0] glyph(input logic [3:0] v);
        case (v)
            4'h0:    glyph = 7'b0000001;
            4'h1:    glyph = 7'b1001111;
            4'h2:    glyph = 7'b0010010;
            4'h3:    glyph = 7'b0000110;
            4'h4:    glyph = 7'b1001100;
            4'h5:    glyph = 7'b0100100;
            4'h6:    glyph = 7'b0100000;
            4'h7:    glyph = 7'b0001111;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0000100;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b1100000;
            4'hC:    glyph = 7'b0110001;
            4'hD:    glyph = 7'b1000010;
            4'hE:    glyph = 7'b0110000;
            default: glyph = 7'b0111000;
        endcase
    endfunction

    logic [SW-1:0]     scan_q, scan_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DIGITS-1:0] dig_q, dig_d;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        nib;

    // Display registers take count_d so a new value reaches the pins on the same edge as count.
    always_comb begin
        scan_d = scan_q + SW'(1);
        idx_d  = idx_q;
        if (scan_q == SW'(SCAN_CYCLES - 1)) begin
            scan_d = '0;
            idx_d  = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
        nib   = '0;
        dig_d = '1;
        for (int d = 0; d < DIGITS; d++) begin
            if (idx_q == IW'(d)) begin
                nib      = count_d[4*d +: 4];
                dig_d[d] = 1'b0;
            end
        end
        seg_d = glyph(nib);
    end

    always_ff @(posedge FPGA_CLK) begin
        if (!RESET_BUT) begin
            count_q <= '0;
            step_q  <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            dig_q   <= '1;
            seg_q   <= '1;
        end else begin
            count_q <= count_d;
            step_q  <= (count_d != count_q);
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            dig_q   <= dig_d;
            seg_q   <= seg_d;
        end
    end

    assign count      = count_q;
    assign step_pulse = step_q;
    assign dig_n      = dig_q;
    assign seg_n      = seg_q;
    assign dot_n      = 1'b1;

endmodule

// File: tb/tb_key_counter_display.sv
// Bench for key_counter_display: a wrapping and a saturating instance share the keys and are
// compared every cycle against a cycle-count based reference model plus directed expectations.
module tb_key_counter_display;

    localparam int DEB = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int SC  = 3;
    localparam int ND  = 2;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       k_inc, k_dec, k_clr;
    logic [7:0] cnt_w, cnt_s;
    logic       stp_w, stp_s;
    logic [1:0] dig_w, dig_s;
    logic [6:0] seg_w, seg_s;
    logic       dot_w, dot_s;

    always #5 clk = ~clk;

    key_counter_display #(
        .DIGITS(ND), .WRAP(1), .REPEAT_EN(1), .DEB_CYCLES(DEB),
        .REP_DELAY_CYCLES(RD), .REP_PERIOD_CYCLES(RP), .SCAN_CYCLES(SC)
    ) dut_w (
        .FPGA_CLK(clk), .RESET_BUT(rst_b), .KEY_INC(k_inc), .KEY_DEC(k_dec), .KEY_CLR(k_clr),
        .count(cnt_w), .step_pulse(stp_w), .dig_n(dig_w), .seg_n(seg_w), .dot_n(dot_w)
    );

    key_counter_display #(
        .DIGITS(ND), .WRAP(0), .REPEAT_EN(1), .DEB_CYCLES(DEB),
        .REP_DELAY_CYCLES(RD), .REP_PERIOD_CYCLES(RP), .SCAN_CYCLES(SC)
    ) dut_s (
        .FPGA_CLK(clk), .RESET_BUT(rst_b), .KEY_INC(k_inc), .KEY_DEC(k_dec), .KEY_CLR(k_clr),
        .count(cnt_s), .step_pulse(stp_s), .dig_n(dig_s), .seg_n(seg_s), .dot_n(dot_s)
    );

    logic [6:0] glyph_t [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    int checks = 0;
    int errors = 0;
    int n_stp_w = 0;
    int n_stp_s = 0;

    // Model state: key index 0 = INC, 1 = DEC, 2 = CLR; all flags mean "pressed".
    int m_cnt [2];
    bit m_stp [2];
    int k_edges = 0;
    int e_edges = 0;
    bit m_s1 [3], m_s2 [3], m_acc [3], m_accp [3], m_tpv [3], m_ev [3];
    int m_run [3], m_tp [3];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit raw_pressed(input int j);
        if (j == 0) return k_inc == 1'b0;
        if (j == 1) return k_dec == 1'b0;
        return k_clr == 1'b0;
    endfunction

    task automatic model_edge();
        int old, nw, d;
        bit an, pr, rep;
        e_edges++;
        if (!rst_b) begin
            k_edges = 0;
            for (int w = 0; w < 2; w++) begin
                m_cnt[w] = 0;
                m_stp[w] = 0;
            end
            for (int j = 0; j < 3; j++) begin
                m_s1[j] = 0; m_s2[j] = 0; m_acc[j] = 0; m_accp[j] = 0;
                m_tpv[j] = 0; m_ev[j] = 0; m_run[j] = 0; m_tp[j] = 0;
            end
        end else begin
            k_edges++;
            for (int w = 0; w < 2; w++) begin
                old = m_cnt[w];
                nw  = old;
                if (m_ev[2]) nw = 0;
                else if (m_ev[0] && m_ev[1]) nw = old;
                else if (m_ev[0]) nw = (w == 0) ? (old + 1) % 256 : ((old == 255) ? 255 : old + 1);
                else if (m_ev[1]) nw = (w == 0) ? (old + 255) % 256 : ((old == 0) ? 0 : old - 1);
                m_stp[w] = (nw != old);
                m_cnt[w] = nw;
            end
            for (int j = 0; j < 3; j++) begin
                an = m_acc[j];
                if (m_s2[j] != m_acc[j]) begin
                    m_run[j]++;
                    if (m_run[j] == DEB) begin
                        an = !m_acc[j];
                        m_run[j] = 0;
                    end
                end else begin
                    m_run[j] = 0;
                end
                pr = m_acc[j] && !m_accp[j];
                m_accp[j] = m_acc[j];
                m_acc[j]  = an;
                if (!m_acc[j]) m_tpv[j] = 0;
                if (pr) begin
                    m_tp[j]  = e_edges;
                    m_tpv[j] = 1;
                end
                rep = 0;
                if (j < 2 && m_acc[j] && m_tpv[j] && !pr) begin
                    d   = e_edges - m_tp[j];
                    rep = (d >= RD) && ((d - RD) % RP == 0);
                end
                m_ev[j] = pr || rep;
                m_s2[j] = m_s1[j];
                m_s1[j] = raw_pressed(j);
            end
        end
    endtask

    task automatic compare_all();
        int idx;
        logic [1:0] edig;
        logic [6:0] eseg_w, eseg_s;
        if (k_edges == 0) begin
            edig = 2'b11; eseg_w = 7'h7F; eseg_s = 7'h7F;
        end else begin
            idx    = ((k_edges - 1) / SC) % ND;
            edig   = (idx == 0) ? 2'b10 : 2'b01;
            eseg_w = glyph_t[(m_cnt[0] >> (4 * idx)) & 15];
            eseg_s = glyph_t[(m_cnt[1] >> (4 * idx)) & 15];
        end
        chk("w_count", cnt_w, m_cnt[0]);
        chk("s_count", cnt_s, m_cnt[1]);
        chk("w_step", stp_w, m_stp[0]);
        chk("s_step", stp_s, m_stp[1]);
        chk("w_dig", dig_w, edig);
        chk("s_dig", dig_s, edig);
        chk("w_seg", seg_w, eseg_w);
        chk("s_seg", seg_s, eseg_s);
        chk("dot", {dot_w, dot_s}, 2'b11);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (stp_w === 1'b1) n_stp_w++;
        if (stp_s === 1'b1) n_stp_s++;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press(input int which, input int hold);
        if (which == 0) k_inc = 1'b0;
        if (which == 1) k_dec = 1'b0;
        if (which == 2) k_clr = 1'b0;
        ticks(hold);
        k_inc = 1'b1; k_dec = 1'b1; k_clr = 1'b1;
        ticks(12);
    endtask

    task automatic hold_inc_until(input logic [7:0] target, input string tag);
        bit hit;
        hit = 0;
        k_inc = 1'b0;
        for (int t = 0; t < 2500 && !hit; t++) begin
            tick();
            if (cnt_w === target) hit = 1;
        end
        k_inc = 1'b1;
        chk(tag, hit, 1'b1);
        ticks(12);
    endtask

    initial begin
        int first, changes, saved;
        logic [1:0] prev;
        rst_b = 1'b0; k_inc = 1'b1; k_dec = 1'b1; k_clr = 1'b1;

        ticks(3);
        chk("rst_count", cnt_w, 8'h00);
        chk("rst_dig", dig_w, 2'b11);
        chk("rst_seg", seg_w, 7'h7F);
        chk("rst_step", stp_w, 1'b0);
        rst_b = 1'b1;
        tick();
        chk("first_dig", dig_w, 2'b10);
        chk("first_seg", seg_w, 7'b0000001);
        ticks(5);

        // Bounce rejection, then one clean press
        for (int r = 0; r < 5; r++) begin
            k_inc = 1'b0; ticks(3);
            k_inc = 1'b1; ticks(3);
        end
        n_stp_w = 0; first = 0;
        k_inc = 1'b0;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (stp_w === 1'b1 && first == 0) first = t;
        end
        k_inc = 1'b1;
        ticks(12);
        chk("bounce_latency", first, 8);
        chk("bounce_pulses", n_stp_w, 1);
        chk("bounce_count", cnt_w, 8'h01);

        // Auto-repeat from zero
        press(2, 8);
        chk("clr_count", cnt_w, 8'h00);
        n_stp_w = 0; first = 0;
        k_inc = 1'b0;
        for (int t = 0; t < 30 && first == 0; t++) begin
            tick();
            if (stp_w === 1'b1) first = 1;
        end
        chk("rep_accept", first, 1);
        ticks(44);
        k_inc = 1'b1;
        chk("rep_steps", n_stp_w, 5);
        chk("rep_count", cnt_w, 8'h05);
        n_stp_w = 0;
        ticks(30);
        chk("rep_stop", n_stp_w, 0);

        // Wrap below zero vs saturate at zero
        press(2, 8);
        n_stp_w = 0; n_stp_s = 0;
        press(1, 8);
        chk("wrap_dec", cnt_w, 8'hFF);
        chk("sat_dec", cnt_s, 8'h00);
        chk("wrap_dec_pulse", n_stp_w, 1);
        chk("sat_dec_pulse", n_stp_s, 0);

        // Saturate at all-ones
        press(2, 8);
        k_inc = 1'b0;
        ticks(2200);
        k_inc = 1'b1;
        ticks(12);
        chk("sat_top", cnt_s, 8'hFF);
        n_stp_s = 0;
        press(0, 8);
        chk("sat_inc", cnt_s, 8'hFF);
        chk("sat_inc_pulse", n_stp_s, 0);

        // INC and DEC together cancel
        saved = m_cnt[0];
        n_stp_w = 0; n_stp_s = 0;
        k_inc = 1'b0; k_dec = 1'b0;
        ticks(8);
        k_inc = 1'b1; k_dec = 1'b1;
        ticks(12);
        chk("cancel_count", cnt_w, saved);
        chk("cancel_pulse", n_stp_w + n_stp_s, 0);

        // CLR wins over INC at 0x37
        press(2, 8);
        hold_inc_until(8'h37, "reach_37");
        chk("at_37", cnt_w, 8'h37);
        n_stp_w = 0;
        k_inc = 1'b0; k_clr = 1'b0;
        ticks(8);
        chk("clr_inc_count", cnt_w, 8'h00);
        chk("clr_inc_step", stp_w, 1'b1);
        k_inc = 1'b1; k_clr = 1'b1;
        ticks(12);
        chk("clr_inc_pulses", n_stp_w, 1);

        // Scan with 0xA5
        hold_inc_until(8'hA5, "reach_a5");
        changes = 0;
        prev = dig_w;
        for (int t = 0; t < 12; t++) begin
            tick();
            chk("scan_dig_valid", (dig_w == 2'b10) || (dig_w == 2'b01), 1'b1);
            chk("scan_seg", seg_w, (dig_w == 2'b10) ? 7'b0100100 : 7'b0001000);
            if (dig_w !== prev) changes++;
            prev = dig_w;
        end
        chk("scan_changes", changes, 4);

        // Reset during a held repeat
        k_inc = 1'b0;
        ticks(40);
        rst_b = 1'b0;
        tick();
        chk("mid_rst_count", cnt_w, 8'h00);
        chk("mid_rst_dig", dig_w, 2'b11);
        chk("mid_rst_seg", seg_w, 7'h7F);
        chk("mid_rst_step", stp_w, 1'b0);
        rst_b = 1'b1;
        first = 0;
        for (int t = 1; t <= 20 && first == 0; t++) begin
            tick();
            if (stp_w === 1'b1) first = t;
        end
        chk("post_rst_latency", first, 8);
        k_inc = 1'b1;
        ticks(12);

        // Random key activity, occasional reset
        for (int s = 0; s < 60; s++) begin
            k_inc = 1'($urandom_range(0, 1));
            k_dec = 1'($urandom_range(0, 1));
            k_clr = ($urandom_range(0, 5) == 0) ? 1'b0 : 1'b1;
            rst_b = ($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1;
            tick();
            rst_b = 1'b1;
            ticks($urandom_range(1, 40));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
